// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF response generator:
// FSM state encoding, pair-index arithmetic and saturating increment.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_CMP    = 3'd3,
    ST_DONE   = 3'd4
  } puf_state_e;

  // Oscillator index for pair k: sel=0 gives a, sel=1 gives b; wraps mod num_ro.
  function automatic int unsigned pair_idx(input int unsigned c,
                                           input int unsigned k,
                                           input int unsigned num_ro,
                                           input int unsigned sel);
    return (c + 2 * k + sel) % num_ro;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Counts 0->1 transitions of one asynchronous oscillator line through a
// 2-flop synchroniser plus history flop; saturating, with synchronous clear.
module puf_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync2_q & ~hist_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_ro_compare.sv
// Ring-oscillator PUF challenge/response generator: measures RESP_W oscillator
// pairs and reports one bit per pair. Optional feature macro: PUF_RO_MARGIN_EN.
//
// state  | meaning
// IDLE   | waiting for start; ro_en = 0
// SETTLE | pair enabled, counters held clear while synchronisers flush
// COUNT  | counting rising edges of both oscillators for WINDOW cycles
// CMP    | one cycle: record resp[k], tie and margin, advance pair
// DONE   | resp_valid high until resp_ready
module puf_ro_compare
  import puf_pkg::*;
#(
  parameter int NUM_RO = 16,
  parameter int CNT_W  = 20,
  parameter int WINDOW = 65536,
  parameter int SETTLE = 16,
  parameter int RESP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RO-1:0]         ro_in,
  output logic [NUM_RO-1:0]         ro_en,
  input  logic [$clog2(NUM_RO)-1:0] challenge,
  input  logic                      start,
  output logic                      busy,
  output logic [RESP_W-1:0]         resp,
  output logic                      resp_tie,
  output logic                      resp_valid,
`ifdef PUF_RO_MARGIN_EN
  output logic [CNT_W-1:0]          resp_margin,
`endif
  input  logic                      resp_ready
);

  localparam int IDX_W   = $clog2(NUM_RO);
  localparam int KW      = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  puf_state_e        state_q, state_d;
  logic [IDX_W-1:0]  chal_q, chal_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              tie_q, tie_d;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              measuring;

  assign idx_a = IDX_W'(pair_idx(32'(chal_q), 32'(k_q), NUM_RO, 0));
  assign idx_b = IDX_W'(pair_idx(32'(chal_q), 32'(k_q), NUM_RO, 1));

  assign measuring = (state_q == ST_SETTLE) || (state_q == ST_COUNT) ||
                     (state_q == ST_CMP);

  always_comb begin
    ro_en = '0;
    if (measuring) begin
      ro_en[idx_a] = 1'b1;
      ro_en[idx_b] = 1'b1;
    end
  end

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_in[idx_a]),
    .clr_i (state_q == ST_SETTLE),
    .en_i  (state_q == ST_COUNT),
    .cnt_o (cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_in[idx_b]),
    .clr_i (state_q == ST_SETTLE),
    .en_i  (state_q == ST_COUNT),
    .cnt_o (cnt_b)
  );

`ifdef PUF_RO_MARGIN_EN
  logic [CNT_W-1:0] margin_q, margin_d;
  logic [CNT_W-1:0] diff;
  assign diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

  always_comb begin
    margin_d = margin_q;
    if (state_q == ST_IDLE && start) begin
      margin_d = '1;
    end else if (state_q == ST_CMP && diff < margin_q) begin
      margin_d = diff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) margin_q <= '1;
    else     margin_q <= margin_d;
  end

  assign resp_margin = margin_q;
`endif

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d  = challenge;
          k_d     = '0;
          tmr_d   = TMR_W'(SETTLE - 1);
          resp_d  = '0;
          tie_d   = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(WINDOW - 1);
          state_d = ST_COUNT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT: begin
        if (tmr_q == '0) state_d = ST_CMP;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_CMP: begin
        resp_d[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie_d = 1'b1;
        if (k_q == KW'(RESP_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          tmr_d   = TMR_W'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chal_q  <= '0;
      k_q     <= '0;
      tmr_q   <= '0;
      resp_q  <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp       = resp_q;
  assign resp_tie   = tie_q;

endmodule
